// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer: opcodes, ALU codes,
// step encoding, instruction classes and the packed control word.
package seq_pkg;

  localparam int OPW = 5;

  localparam logic [4:0] ALU_ADD     = 5'd0;
  localparam logic [4:0] ALU_AND     = 5'd2;
  localparam logic [4:0] ALU_OR      = 5'd3;
  localparam logic [4:0] PC_INC_CODE = 5'd31;

  localparam logic [OPW-1:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3;
  localparam logic [OPW-1:0] OP_SHR  = 5'd4,  OP_SHRA = 5'd5,  OP_SHL  = 5'd6,  OP_ROR  = 5'd7;
  localparam logic [OPW-1:0] OP_ROL  = 5'd8,  OP_MUL  = 5'd9,  OP_DIV  = 5'd10, OP_NEG  = 5'd11;
  localparam logic [OPW-1:0] OP_NOT  = 5'd12, OP_ADDI = 5'd13, OP_ANDI = 5'd14, OP_ORI  = 5'd15;
  localparam logic [OPW-1:0] OP_LD   = 5'd16, OP_LDI  = 5'd17, OP_ST   = 5'd18, OP_BR   = 5'd19;
  localparam logic [OPW-1:0] OP_JR   = 5'd20, OP_IN   = 5'd21, OP_OUT  = 5'd22, OP_MFHI = 5'd23;
  localparam logic [OPW-1:0] OP_MFLO = 5'd24, OP_NOP  = 5'd25, OP_HALT = 5'd26;

  typedef enum logic [3:0] {
    S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
    S_T4 = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7,
    S_HALT = 4'd8, S_PAUSE = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    IC_ALU, IC_MULDIV, IC_UNARY, IC_IMM, IC_LD, IC_LDI, IC_ST, IC_BR,
    IC_JR, IC_IN, IC_OUT, IC_MFHI, IC_MFLO, IC_NOP, IC_HALT
  } iclass_t;

  typedef struct packed {
    logic gra, grb, grc, rIn, rOut, baOut;
    logic hiIn, loIn, zIn, pcIn, mdrIn, marIn, yIn, oportIn, irIn;
    logic hiOut, loOut, zhiOut, zloOut, pcOut, mdrOut, iportOut, cOut;
    logic conIn, read, write;
    logic [4:0] aluCode;
  } ctrl_t;

endpackage

// File: rtl/seq_decode.sv
// Opcode to instruction class and final execute step; purely combinational.
module seq_decode
  import seq_pkg::*;
(
  input  logic [OPW-1:0] opcode,
  output iclass_t        iClass,
  output state_t         lastStep
);

  always_comb begin
    iClass   = IC_NOP;
    lastStep = S_T2;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: begin
        iClass = IC_ALU; lastStep = S_T5;
      end
      OP_MUL, OP_DIV:             begin iClass = IC_MULDIV; lastStep = S_T6; end
      OP_NEG, OP_NOT:             begin iClass = IC_UNARY;  lastStep = S_T4; end
      OP_ADDI, OP_ANDI, OP_ORI:   begin iClass = IC_IMM;    lastStep = S_T5; end
      OP_LD:                      begin iClass = IC_LD;     lastStep = S_T7; end
      OP_LDI:                     begin iClass = IC_LDI;    lastStep = S_T5; end
      OP_ST:                      begin iClass = IC_ST;     lastStep = S_T7; end
      OP_BR:                      begin iClass = IC_BR;     lastStep = S_T6; end
      OP_JR:                      begin iClass = IC_JR;     lastStep = S_T3; end
      OP_IN:                      begin iClass = IC_IN;     lastStep = S_T3; end
      OP_OUT:                     begin iClass = IC_OUT;    lastStep = S_T3; end
      OP_MFHI:                    begin iClass = IC_MFHI;   lastStep = S_T3; end
      OP_MFLO:                    begin iClass = IC_MFLO;   lastStep = S_T3; end
      OP_HALT:                    begin iClass = IC_HALT;   lastStep = S_T2; end
      default:                    begin iClass = IC_NOP;    lastStep = S_T2; end
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control-step sequencer: fetch T0-T2, execute T3-T7, HALT; memory steps wait on mem_ready.
// Optional single-step PAUSE state is built when SEQ_STEP_EN is defined.
module instr_sequencer
  import seq_pkg::*;
(
  input  logic       clock,
  input  logic       clear,
`ifdef SEQ_STEP_EN
  input  logic       step_mode,
  input  logic       step,
`endif
  input  logic [31:0] ir,
  input  logic       con_ff,
  input  logic       mem_ready,
  input  logic       stop,
  output logic       gra, grb, grc, r_in, r_out, ba_out,
  output logic       hi_in, lo_in, z_in, pc_in, mdr_in, mar_in, y_in, oport_in, ir_in,
  output logic       hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, iport_out, c_out,
  output logic       con_in, read, write,
  output logic [4:0] alu_code,
  output logic       run,
  output logic [3:0] t_state
);

  state_t          state, stateNext, lastStep, boundaryNext;
  iclass_t         iClass;
  ctrl_t           ctrl;
  logic [OPW-1:0]  opcode;
  logic [4:0]      immAlu;
  logic            memWait;
  logic            unusedIr;

  assign opcode   = ir[31:27];
  assign unusedIr = ^ir[26:0];   // operand fields are consumed by the register select block
  assign immAlu   = (opcode == OP_ANDI) ? ALU_AND : (opcode == OP_ORI) ? ALU_OR : ALU_ADD;

  seq_decode uDecode (.opcode(opcode), .iClass(iClass), .lastStep(lastStep));

  always_ff @(posedge clock) begin
    if (clear) state <= S_T0;
    else       state <= stateNext;
  end

  assign memWait = (state == S_T1) || (state == S_T6 && iClass == IC_LD) ||
                   (state == S_T7 && iClass == IC_ST);

  always_comb begin
    boundaryNext = S_T0;
    if (stop || iClass == IC_HALT) boundaryNext = S_HALT;
`ifdef SEQ_STEP_EN
    else if (step_mode)            boundaryNext = S_PAUSE;
`endif
  end

  always_comb begin
    stateNext = S_T0;
    case (state)
      S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (memWait && !mem_ready) stateNext = state;
        else if (state == lastStep) stateNext = boundaryNext;
        else                        stateNext = state_t'(state + 4'd1);
      end
      S_HALT:  stateNext = S_HALT;
`ifdef SEQ_STEP_EN
      S_PAUSE: stateNext = stop ? S_HALT : (step ? S_T0 : S_PAUSE);
`endif
      default: stateNext = S_T0;
    endcase
  end

  always_comb begin
    ctrl = '0;
    if (!clear) begin
      case (state)
        S_T0: begin ctrl.pcOut = 1'b1; ctrl.marIn = 1'b1; ctrl.zIn = 1'b1; ctrl.aluCode = PC_INC_CODE; end
        S_T1: begin ctrl.zloOut = 1'b1; ctrl.pcIn = 1'b1; ctrl.read = 1'b1; ctrl.mdrIn = 1'b1; end
        S_T2: begin ctrl.mdrOut = 1'b1; ctrl.irIn = 1'b1; end
        S_T3: case (iClass)
          IC_ALU, IC_IMM:        begin ctrl.grb = 1'b1; ctrl.rOut = 1'b1; ctrl.yIn = 1'b1; end
          IC_LD, IC_LDI, IC_ST:  begin ctrl.grb = 1'b1; ctrl.baOut = 1'b1; ctrl.yIn = 1'b1; end
          IC_MULDIV:             begin ctrl.gra = 1'b1; ctrl.rOut = 1'b1; ctrl.yIn = 1'b1; end
          IC_UNARY: begin ctrl.grb = 1'b1; ctrl.rOut = 1'b1; ctrl.zIn = 1'b1; ctrl.aluCode = opcode; end
          IC_BR:    begin ctrl.gra = 1'b1; ctrl.rOut = 1'b1; ctrl.conIn = 1'b1; end
          IC_JR:    begin ctrl.gra = 1'b1; ctrl.rOut = 1'b1; ctrl.pcIn = 1'b1; end
          IC_IN:    begin ctrl.iportOut = 1'b1; ctrl.gra = 1'b1; ctrl.rIn = 1'b1; end
          IC_OUT:   begin ctrl.gra = 1'b1; ctrl.rOut = 1'b1; ctrl.oportIn = 1'b1; end
          IC_MFHI:  begin ctrl.hiOut = 1'b1; ctrl.gra = 1'b1; ctrl.rIn = 1'b1; end
          IC_MFLO:  begin ctrl.loOut = 1'b1; ctrl.gra = 1'b1; ctrl.rIn = 1'b1; end
          default: ;
        endcase
        S_T4: case (iClass)
          IC_ALU:    begin ctrl.grc = 1'b1; ctrl.rOut = 1'b1; ctrl.zIn = 1'b1; ctrl.aluCode = opcode; end
          IC_MULDIV: begin ctrl.grb = 1'b1; ctrl.rOut = 1'b1; ctrl.zIn = 1'b1; ctrl.aluCode = opcode; end
          IC_UNARY:  begin ctrl.zloOut = 1'b1; ctrl.gra = 1'b1; ctrl.rIn = 1'b1; end
          IC_IMM:    begin ctrl.cOut = 1'b1; ctrl.zIn = 1'b1; ctrl.aluCode = immAlu; end
          IC_LD, IC_LDI, IC_ST: begin ctrl.cOut = 1'b1; ctrl.zIn = 1'b1; ctrl.aluCode = ALU_ADD; end
          IC_BR:     begin ctrl.pcOut = 1'b1; ctrl.yIn = 1'b1; end
          default: ;
        endcase
        S_T5: case (iClass)
          IC_ALU, IC_IMM, IC_LDI: begin ctrl.zloOut = 1'b1; ctrl.gra = 1'b1; ctrl.rIn = 1'b1; end
          IC_MULDIV:   begin ctrl.zloOut = 1'b1; ctrl.loIn = 1'b1; end
          IC_LD, IC_ST: begin ctrl.zloOut = 1'b1; ctrl.marIn = 1'b1; end
          IC_BR:       begin ctrl.cOut = 1'b1; ctrl.zIn = 1'b1; ctrl.aluCode = ALU_ADD; end
          default: ;
        endcase
        S_T6: case (iClass)
          IC_MULDIV: begin ctrl.zhiOut = 1'b1; ctrl.hiIn = 1'b1; end
          IC_LD:     begin ctrl.read = 1'b1; ctrl.mdrIn = 1'b1; end
          IC_ST:     begin ctrl.gra = 1'b1; ctrl.rOut = 1'b1; ctrl.mdrIn = 1'b1; end
          IC_BR:     begin ctrl.zloOut = con_ff; ctrl.pcIn = con_ff; end
          default: ;
        endcase
        S_T7: case (iClass)
          IC_LD:   begin ctrl.mdrOut = 1'b1; ctrl.gra = 1'b1; ctrl.rIn = 1'b1; end
          IC_ST:   ctrl.write = 1'b1;
          default: ;
        endcase
        default: ;
      endcase
    end
  end

  assign {gra, grb, grc, r_in, r_out, ba_out}                               = {ctrl.gra, ctrl.grb, ctrl.grc, ctrl.rIn, ctrl.rOut, ctrl.baOut};
  assign {hi_in, lo_in, z_in, pc_in, mdr_in, mar_in, y_in, oport_in, ir_in} = {ctrl.hiIn, ctrl.loIn, ctrl.zIn, ctrl.pcIn, ctrl.mdrIn,
                                                                               ctrl.marIn, ctrl.yIn, ctrl.oportIn, ctrl.irIn};
  assign {hi_out, lo_out, zhi_out, zlo_out}                                 = {ctrl.hiOut, ctrl.loOut, ctrl.zhiOut, ctrl.zloOut};
  assign {pc_out, mdr_out, iport_out, c_out}                                = {ctrl.pcOut, ctrl.mdrOut, ctrl.iportOut, ctrl.cOut};
  assign {con_in, read, write}                                              = {ctrl.conIn, ctrl.read, ctrl.write};
  assign alu_code = ctrl.aluCode;
  assign run      = (state != S_HALT);
  assign t_state  = state;

endmodule
